// File: rtl/adc_multi_read_ctrl_pkg.sv
// Shared types for the multi-channel ADC capture read controller.
package adc_rd_pkg;

   // FSM encoding; code 2'b11 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRAIN = 2'b01,
      GAP   = 2'b10
   } rd_state_t;

   // Frame length modes.
   localparam logic MODE_DRAIN = 1'b0;
   localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/adc_multi_read_ctrl_rr_arbiter.sv
// Combinational rotate-priority arbiter: the requester just after ptr wins.
// Shared with the other stream multiplexers.
module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         valid
);

   // Scan ptr+1, ptr+2, ... modulo N and take the first active request.
   always_comb begin : scan
      int idx;
      idx   = 0;
      grant = '0;
      valid = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            grant = W'(idx);
         end
      end
   end

endmodule

// File: rtl/adc_multi_read_ctrl.sv
// Multi-channel ADC capture FIFO read controller. Picks a full FIFO in
// round-robin order, drains it into the Ethernet packetiser with frame
// markers, then holds off for a programmable gap before the next frame.
module adc_multi_read_ctrl
   import adc_rd_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 16,
   parameter  int GAP_W  = 8,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] empty,
   input  logic              fifo_rst,
   input  logic              mode,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic [GAP_W-1:0]  gap_cyc,
   output logic [NUM_CH-1:0] rd_en,
   output logic              eth_en,
   output logic              eth_sof,
   output logic              eth_eof,
   output logic [CH_W-1:0]   ch_sel,
   output logic [CNT_W-1:0]  last_len,
   output logic              abort,
   output logic [1:0]        state
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_GAP   = GAP;

   logic [CH_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [GAP_W-1:0]  gap_cnt;
   logic              mode_q;
   logic [CNT_W-1:0]  blen_q;
   logic [NUM_CH-1:0] eligible;
   logic [CH_W-1:0]   grant;
   logic              grant_vld;
   logic              mode1_eff;
   logic              drain_exit;

   // A FIFO under reset is never picked.
   assign eligible = full & {NUM_CH{~fifo_rst}};

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_vld)
   );

   // Burst limit only applies when a non-zero length was latched at frame start.
   assign mode1_eff  = (mode_q == MODE_BURST) && (blen_q != '0);
   assign drain_exit = empty[ch_sel] | (mode1_eff & (cnt == blen_q - CNT_W'(1)));
   // Length of the frame ending this cycle; sticks at all-ones on overflow.
   assign cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // Frame sequencing: grant, drain, optional gap.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= S_IDLE;
         ch_sel   <= '0;
         rr_ptr   <= CH_W'(NUM_CH - 1);
         cnt      <= '0;
         gap_cnt  <= '0;
         last_len <= '0;
         mode_q   <= MODE_DRAIN;
         blen_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  ch_sel <= grant;
                  rr_ptr <= grant;
                  cnt    <= '0;
                  mode_q <= mode;
                  blen_q <= burst_len;
                  state  <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_rst) begin
                  // Aborted frame: no length report, straight back to IDLE.
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt_inc;
                  if (drain_exit) begin
                     last_len <= cnt_inc;
                     if (gap_cyc != '0) begin
                        gap_cnt <= gap_cyc - GAP_W'(1);
                        state   <= S_GAP;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) state <= S_IDLE;
               else               gap_cnt <= gap_cnt - GAP_W'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read strobes and frame markers follow the current state directly.
   always_comb begin
      rd_en   = '0;
      eth_en  = 1'b0;
      eth_sof = 1'b0;
      eth_eof = 1'b0;
      abort   = 1'b0;
      if (state == S_DRAIN) begin
         if (fifo_rst) begin
            abort = 1'b1;
         end else begin
            rd_en[ch_sel] = 1'b1;
            eth_en        = 1'b1;
            eth_sof       = (cnt == '0);
            eth_eof       = drain_exit;
         end
      end
   end

endmodule

// File: tb/tb_adc_multi_read_ctrl.sv
// Directed bench for adc_multi_read_ctrl with a small FIFO model and a
// frame scoreboard (expected frames queued at stimulus, matched on eof/abort).
module tb_adc_multi_read_ctrl;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_DRAIN = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;

   typedef struct {
      int ch;
      int len;
      int ab;
   } frm_t;

   logic        clk;
   logic        rstn;
   logic [3:0]  full;
   logic [3:0]  empty;
   logic        fifo_rst;
   logic        mode;
   logic [15:0] burst_len;
   logic [7:0]  gap_cyc;
   logic [3:0]  rd_en;
   logic        eth_en;
   logic        eth_sof;
   logic        eth_eof;
   logic [1:0]  ch_sel;
   logic [15:0] last_len;
   logic        abort;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int proto_bad = 0;
   int mon_cnt = 0;
   int exp_last = 0;
   frm_t exp_q[$];
   frm_t obs_q[$];

   // FIFO model: set_pulse loads a FIFO (full, words left after the next
   // read); empty shows once no further word remains beyond the current one.
   logic [3:0] full_m;
   int         rem_m[4];
   logic [3:0] set_pulse;
   int         set_rem[4];

   adc_multi_read_ctrl #(.NUM_CH(4), .CNT_W(16), .GAP_W(8)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .full      (full),
      .empty     (empty),
      .fifo_rst  (fifo_rst),
      .mode      (mode),
      .burst_len (burst_len),
      .gap_cyc   (gap_cyc),
      .rd_en     (rd_en),
      .eth_en    (eth_en),
      .eth_sof   (eth_sof),
      .eth_eof   (eth_eof),
      .ch_sel    (ch_sel),
      .last_len  (last_len),
      .abort     (abort),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model update
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!rstn) begin
            full_m[i] <= 1'b0;
            rem_m[i]  <= 0;
         end else if (set_pulse[i]) begin
            full_m[i] <= 1'b1;
            rem_m[i]  <= set_rem[i];
         end else if (rd_en[i]) begin
            full_m[i] <= 1'b0;
            if (rem_m[i] != 0) rem_m[i] <= rem_m[i] - 1;
         end
      end
   end

   assign full = full_m;

   // Empty flags from model levels
   always_comb begin
      empty = '0;
      for (int i = 0; i < 4; i++) empty[i] = (rem_m[i] == 0);
   end

   // Output monitor: assembles frames and flags protocol breaks.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mon_cnt = 0;
         end else if (abort) begin
            if (eth_en || rd_en != 4'b0 || eth_sof || eth_eof) proto_bad++;
            obs_q.push_back('{int'(ch_sel), mon_cnt, 1});
            mon_cnt = 0;
         end else if (eth_en) begin
            if (rd_en !== (4'b0001 << ch_sel)) proto_bad++;
            if (eth_sof !== (mon_cnt == 0)) proto_bad++;
            mon_cnt++;
            if (eth_eof) begin
               obs_q.push_back('{int'(ch_sel), mon_cnt, 0});
               mon_cnt = 0;
            end
         end else if (rd_en != 4'b0 || eth_sof || eth_eof) begin
            proto_bad++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int ch, input int len, input int ab);
      exp_q.push_back('{ch, len, ab});
   endtask

   // Wait (bounded) for the next observed frame and match it to the scoreboard.
   task automatic expect_frame(input string tag);
      frm_t o;
      frm_t e;
      int   n;
      n = 0;
      while (obs_q.size() == 0 && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_arrived"}, 32'(obs_q.size() > 0), 1);
      if (obs_q.size() == 0 || exp_q.size() == 0) return;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_ch"},  o.ch,  e.ch);
      chk({tag, "_len"}, o.len, e.len);
      chk({tag, "_abort"}, o.ab, e.ab);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (state !== ST_DRAIN && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_drain_start"}, 32'(state), 32'(ST_DRAIN));
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
      exp_last = 0;
   endtask

   initial begin
      rstn      = 1'b0;
      fifo_rst  = 1'b0;
      mode      = 1'b0;
      burst_len = 16'd0;
      gap_cyc   = 8'd0;
      set_pulse = 4'b0;
      for (int i = 0; i < 4; i++) set_rem[i] = 0;
      tick();
      tick();
      tick();

      // Reset state
      chk("rst_state",    32'(state),    32'(ST_IDLE));
      chk("rst_rd_en",    32'(rd_en),    0);
      chk("rst_eth_en",   32'(eth_en),   0);
      chk("rst_sof",      32'(eth_sof),  0);
      chk("rst_eof",      32'(eth_eof),  0);
      chk("rst_abort",    32'(abort),    0);
      chk("rst_ch_sel",   32'(ch_sel),   0);
      chk("rst_last_len", 32'(last_len), 0);
      rstn = 1'b1;
      tick();

      // Mode 0, ch1, six-word frame
      set_rem[1] = 5; set_pulse = 4'b0010; push_exp(1, 6, 0);
      tick();
      set_pulse = 4'b0;
      expect_frame("m0_ch1");
      chk("m0_last_len", 32'(last_len), 6);
      chk("m0_ch_sel",   32'(ch_sel),   1);

      // Round robin from reset with a 3-cycle gap
      do_reset();
      gap_cyc = 8'd3;
      set_rem[0] = 1; set_rem[2] = 2; set_pulse = 4'b0101;
      push_exp(0, 2, 0); push_exp(2, 3, 0);
      tick();
      set_pulse = 4'b0;
      expect_frame("rr_a");
      chk("gap_c1", 32'(state), 32'(ST_GAP));
      tick();
      chk("gap_c2", 32'(state), 32'(ST_GAP));
      tick();
      chk("gap_c3", 32'(state), 32'(ST_GAP));
      tick();
      chk("gap_end", 32'(state), 32'(ST_IDLE));
      expect_frame("rr_b");
      chk("rr_last_len", 32'(last_len), 3);
      // Pointer now at 2, so ch0 leads again
      set_rem[0] = 0; set_rem[2] = 0; set_pulse = 4'b0101;
      push_exp(0, 1, 0); push_exp(2, 1, 0);
      tick();
      set_pulse = 4'b0;
      expect_frame("rr_c");
      expect_frame("rr_d");

      // Fixed bursts
      gap_cyc = 8'd0; mode = 1'b1; burst_len = 16'd4;
      set_rem[3] = 100; set_pulse = 4'b1000; push_exp(3, 4, 0);
      tick();
      set_pulse = 4'b0;
      expect_frame("burst4");
      chk("burst4_last_len", 32'(last_len), 4);
      burst_len = 16'd0;
      set_rem[3] = 2; set_pulse = 4'b1000; push_exp(3, 3, 0);
      tick();
      set_pulse = 4'b0;
      expect_frame("burst0");
      chk("burst0_last_len", 32'(last_len), 3);
      // Mode change mid-frame is ignored
      burst_len = 16'd4;
      set_rem[1] = 9; set_pulse = 4'b0010; push_exp(1, 4, 0);
      tick();
      set_pulse = 4'b0;
      wait_drain("midchg");
      mode = 1'b0; burst_len = 16'd0;
      expect_frame("midchg");
      exp_last = 4;

      // Abort on the 3rd DRAIN cycle
      set_rem[2] = 10; set_pulse = 4'b0100; push_exp(2, 2, 1);
      tick();
      set_pulse = 4'b0;
      wait_drain("abort");
      tick();
      tick();
      fifo_rst = 1'b1;
      #1;
      chk("abort_pulse",  32'(abort),   1);
      chk("abort_rd_en",  32'(rd_en),   0);
      chk("abort_eth_en", 32'(eth_en),  0);
      chk("abort_eof",    32'(eth_eof), 0);
      tick();
      #1;
      chk("abort_idle",  32'(state), 32'(ST_IDLE));
      chk("abort_clear", 32'(abort), 0);
      chk("abort_last_len", 32'(last_len), 32'(exp_last));
      expect_frame("abort");

      // fifo_rst holds off a full channel; then one-word frame
      set_rem[0] = 0; set_pulse = 4'b0001; push_exp(0, 1, 0);
      tick();
      set_pulse = 4'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("blocked_idle", 32'(state), 32'(ST_IDLE));
      end
      fifo_rst = 1'b0;
      tick();
      chk("unblock_drain", 32'(state), 32'(ST_DRAIN));
      #1;
      chk("oneword_sof", 32'(eth_sof), 1);
      chk("oneword_eof", 32'(eth_eof), 1);
      expect_frame("oneword");
      chk("oneword_last_len", 32'(last_len), 1);

      // Reset in the middle of a drain
      set_rem[1] = 20; set_pulse = 4'b0010;
      tick();
      set_pulse = 4'b0;
      wait_drain("rstmid");
      tick();
      rstn = 1'b0;
      tick();
      #1;
      chk("rstmid_state",    32'(state),    32'(ST_IDLE));
      chk("rstmid_rd_en",    32'(rd_en),    0);
      chk("rstmid_eth_en",   32'(eth_en),   0);
      chk("rstmid_ch_sel",   32'(ch_sel),   0);
      chk("rstmid_last_len", 32'(last_len), 0);
      rstn = 1'b1;
      tick();
      set_rem[0] = 0; set_rem[2] = 0; set_pulse = 4'b0101;
      push_exp(0, 1, 0); push_exp(2, 1, 0);
      tick();
      set_pulse = 4'b0;
      expect_frame("post_rst_a");
      expect_frame("post_rst_b");

      // Global protocol and scoreboard drain
      repeat (5) tick();
      chk("protocol", proto_bad, 0);
      chk("obs_left", obs_q.size(), 0);
      chk("exp_left", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
